pc_fetch: RTL
=============

Name: pc_fetch

Overview:
- Fetch-side counterpart of the next-PC calculator: owns the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched instruction downstream over a valid/ready handshake, along with PC, PC+4 and the 26-bit and 16-bit immediate fields.
- Accepts the computed next PC back as a redirect.
- Sits between instruction memory and decode, and closes the loop with the next-PC logic.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; must be word aligned.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, registered
imem_addr  out  32  fetch word address, registered, bits [1:0] always 0
imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle
imem_rdata  in  32  fetched instruction word
if_valid  out  1  fetched instruction available, registered
if_ready  in  1  downstream accepts the instruction
if_pc  out  32  address of the held instruction
if_pc4  out  32  if_pc + 4, combinational, modulo 2^32
if_instr  out  32  held instruction
if_i26  out  26  if_instr[25:0]
if_i16  out  16  if_instr[15:0]
redirect  in  1  load npc_in as the next PC
npc_in  in  32  redirect target; bits [1:0] ignored and treated as 00

Behaviour:
- Reset values: state=RST, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0.
- States: RST, FETCH, DRAIN, HOLD. pc is the address of the next instruction to fetch.
- RST: the first clock edge after reset deasserts sets imem_req=1, imem_addr=pc, and moves to FETCH. A redirect in RST loads pc and imem_addr from npc_in.
- FETCH: imem_req is held at 1 and imem_addr is held stable until imem_ack.
  - ack, no redirect: if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1, imem_req<=0, go to HOLD. if_valid rises the cycle after ack.
  - ack with redirect: discard imem_rdata; pc and imem_addr <= npc_in; imem_req stays 1; stay in FETCH.
  - redirect, no ack: pc<=npc_in; imem_req and imem_addr stay unchanged because the request is still outstanding; go to DRAIN.
- DRAIN: imem_req stays 1 with the old address.
  - redirect: pc<=npc_in, latest redirect wins.
  - ack: discard imem_rdata; imem_addr<=pc (or npc_in if redirect is high in the same cycle); imem_req stays 1; go to FETCH.
  - No instruction is ever delivered from a drained request.
- HOLD: if_valid=1; if_pc and if_instr are held stable until transfer (if_valid & if_ready).
  - transfer: if_valid<=0; next = redirect ? npc_in : pc+4; pc<=next; imem_addr<=next; imem_req<=1; go to FETCH.
  - redirect, no ready: the instruction is dropped (if_valid<=0); pc and imem_addr <= npc_in; imem_req<=1; go to FETCH.
- Redirect has priority over sequential increment in every state.
- imem_ack while imem_req=0 is ignored.
- PC arithmetic wraps at 2^32: pc 32'hFFFF_FFFC + 4 = 0.
- Throughput: at most one instruction per 2 cycles, with a zero-wait-state memory and if_ready held high.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous); outstanding requests are abandoned, and an ack arriving after reset is ignored.

Test Plan:
- Reset release, memory acks 1 cycle after each req, if_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; if_pc matches each; if_pc4 = 0x3004 while if_pc=0x3000; imem_rdata 0x0800_0C03 gives if_i26=0x0000C03, if_i16=0x0C03.
- Backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr stay stable; imem_req stays 0; a single fetch follows once ready rises.
- Redirect with a request outstanding (no ack), npc_in=0x0000_4000 -> state DRAIN; the next ack's data is never presented; the next imem_addr is 0x4000.
- Redirect together with transfer in HOLD, npc_in=0x0000_3100 -> next imem_addr=0x3100, not if_pc+4; redirect in HOLD with if_ready=0 -> if_valid drops and the instruction is never transferred.
- Wrap and alignment: redirect to npc_in=0xFFFF_FFFF -> imem_addr=0xFFFF_FFFC; the next sequential fetch goes to 0x0000_0000.
- Reset asserted while in DRAIN, with an ack arriving one cycle later -> all outputs at reset values immediately; the late ack is ignored; after release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/pc_fetch.sv
// Fetch unit: owns the architectural PC, issues word fetches over req/ack, and
// hands instructions downstream over valid/ready. Redirects from next-PC logic win over PC+4.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] if_instr,
   output logic [25:0] if_i26,
   output logic [15:0] if_i16,
   input  logic        redirect,
   input  logic [31:0] npc_in
);

   localparam int unsigned XLEN    = 32;
   localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   state_e            state_q;
   logic [XLEN-1:0]   pc_q;
   logic              req_q;
   logic [XLEN-1:0]   addr_q;
   logic              valid_q;
   logic [XLEN-1:0]   if_pc_q;
   logic [XLEN-1:0]   instr_q;

   logic [XLEN-1:0]   npc_al_d;
   logic [XLEN-1:0]   seq_pc_d;
   logic              xfer_d;

   assign npc_al_d = npc_in & ~XLEN'(3);
   assign seq_pc_d = redirect ? npc_al_d : pc_q + XLEN'(4);
   assign xfer_d   = valid_q & if_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RST;
         pc_q    <= PC_INIT;
         req_q   <= 1'b0;
         addr_q  <= PC_INIT;
         valid_q <= 1'b0;
         if_pc_q <= PC_INIT;
         instr_q <= '0;
      end else begin
         unique case (state_q)
            ST_RST: begin
               req_q   <= 1'b1;
               state_q <= ST_FETCH;
               if (redirect) begin
                  pc_q   <= npc_al_d;
                  addr_q <= npc_al_d;
               end else begin
                  addr_q <= pc_q;
               end
            end
            ST_FETCH: begin
               if (imem_ack && redirect) begin
                  // Wrong-path data: reissue straight at the redirect target.
                  pc_q   <= npc_al_d;
                  addr_q <= npc_al_d;
               end else if (imem_ack) begin
                  instr_q <= imem_rdata;
                  if_pc_q <= addr_q;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= ST_HOLD;
               end else if (redirect) begin
                  pc_q    <= npc_al_d;
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Outstanding request must complete before a new address is issued.
               if (redirect) begin
                  pc_q <= npc_al_d;
               end
               if (imem_ack) begin
                  addr_q  <= redirect ? npc_al_d : pc_q;
                  state_q <= ST_FETCH;
               end
            end
            ST_HOLD: begin
               if (xfer_d || redirect) begin
                  valid_q <= 1'b0;
                  pc_q    <= seq_pc_d;
                  addr_q  <= seq_pc_d;
                  req_q   <= 1'b1;
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_RST;
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign if_valid  = valid_q;
   assign if_pc     = if_pc_q;
   assign if_pc4    = if_pc_q + XLEN'(4);
   assign if_instr  = instr_q;
   assign if_i26    = instr_q[25:0];
   assign if_i16    = instr_q[15:0];

endmodule
